// File: rtl/encoder_42.sv
// encoder_42 -- 4-to-2 priority encoder with optional output registers.
//
// Compresses a 4-bit request vector into the binary index of the winning
// asserted bit, plus status flags for "any request" and "more than one
// request".
//
// Parameters:
//   MSB_PRIORITY  1: highest-index set bit wins; 0: lowest-index set bit wins
//   REG_OUT       1: outputs registered (one-cycle latency)
//                 0: outputs follow w combinationally
//
// Ports:
//   clk    in   1  system clock, rising-edge active
//   rst_n  in   1  asynchronous active-low reset
//   w      in   4  request vector, any pattern legal
//   y      out  2  index of the winning set bit (0 when no bit is set)
//   valid  out  1  at least one bit of w is set
//   multi  out  1  two or more bits of w are set
module encoder_42 #(
  parameter bit MSB_PRIORITY = 1'b1,
  parameter bit REG_OUT      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] w,
  output logic [1:0] y,
  output logic       valid,
  output logic       multi
);

  logic [1:0] enc_y;
  logic       enc_valid;
  logic       enc_multi;

  logic [1:0] y_q;
  logic       valid_q;
  logic       multi_q;

  // Winner selection. With no bit set the index falls back to 0, so
  // consumers must qualify y with valid.
  always_comb begin
    enc_y = '0;
    if (MSB_PRIORITY) begin
      if (w[3])      enc_y = 2'd3;
      else if (w[2]) enc_y = 2'd2;
      else if (w[1]) enc_y = 2'd1;
      else           enc_y = 2'd0;
    end else begin
      if (w[0])      enc_y = 2'd0;
      else if (w[1]) enc_y = 2'd1;
      else if (w[2]) enc_y = 2'd2;
      else if (w[3]) enc_y = 2'd3;
      else           enc_y = 2'd0;
    end
  end

  assign enc_valid = |w;
  // Clearing the lowest set bit leaves something behind only when at
  // least two bits were set.
  assign enc_multi = |(w & (w - 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      y_q     <= enc_y;
      valid_q <= enc_valid;
      multi_q <= enc_multi;
    end
  end

  assign y     = REG_OUT ? y_q     : enc_y;
  assign valid = REG_OUT ? valid_q : enc_valid;
  assign multi = REG_OUT ? multi_q : enc_multi;

endmodule

// File: tb/tb_encoder_42.sv
// Testbench for encoder_42: MSB-priority registered, LSB-priority registered
// and MSB-priority combinational instances share one stimulus vector.
module tb_encoder_42;

  logic       clk;
  logic       rst_n;
  logic [3:0] w;

  logic [1:0] y_m, y_l, y_c;
  logic       valid_m, valid_l, valid_c;
  logic       multi_m, multi_l, multi_c;

  int unsigned checks;
  int unsigned failures;

  encoder_42 #(.MSB_PRIORITY(1'b1), .REG_OUT(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .w(w), .y(y_m), .valid(valid_m), .multi(multi_m)
  );

  encoder_42 #(.MSB_PRIORITY(1'b0), .REG_OUT(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .w(w), .y(y_l), .valid(valid_l), .multi(multi_l)
  );

  encoder_42 #(.MSB_PRIORITY(1'b1), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .w(w), .y(y_c), .valid(valid_c), .multi(multi_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [3:0] w;
    logic [1:0] y_msb;
    logic [1:0] y_lsb;
    logic       valid;
    logic       multi;
  } vec_t;

  vec_t vecs[17];
  vec_t prev;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (w=%b t=%0t)", name, act, exp, w, $time);
    end
  endtask

  task automatic chk_msb(input string name, input logic [1:0] ey, input logic ev, input logic em);
    chk({name, ".y"},     {2'b00, y_m},     {2'b00, ey});
    chk({name, ".valid"}, {3'b000, valid_m}, {3'b000, ev});
    chk({name, ".multi"}, {3'b000, multi_m}, {3'b000, em});
  endtask

  task automatic chk_lsb(input string name, input logic [1:0] ey, input logic ev, input logic em);
    chk({name, ".y"},     {2'b00, y_l},     {2'b00, ey});
    chk({name, ".valid"}, {3'b000, valid_l}, {3'b000, ev});
    chk({name, ".multi"}, {3'b000, multi_l}, {3'b000, em});
  endtask

  task automatic chk_comb(input string name, input logic [1:0] ey, input logic ev, input logic em);
    chk({name, ".y"},     {2'b00, y_c},     {2'b00, ey});
    chk({name, ".valid"}, {3'b000, valid_c}, {3'b000, ev});
    chk({name, ".multi"}, {3'b000, multi_c}, {3'b000, em});
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //              w        y_msb  y_lsb  valid multi
    vecs[0]  = '{4'b0000, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0001, 2'd0, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{4'b0010, 2'd1, 2'd1, 1'b1, 1'b0};
    vecs[3]  = '{4'b0011, 2'd1, 2'd0, 1'b1, 1'b1};
    vecs[4]  = '{4'b0100, 2'd2, 2'd2, 1'b1, 1'b0};
    vecs[5]  = '{4'b0101, 2'd2, 2'd0, 1'b1, 1'b1};
    vecs[6]  = '{4'b0110, 2'd2, 2'd1, 1'b1, 1'b1};
    vecs[7]  = '{4'b0111, 2'd2, 2'd0, 1'b1, 1'b1};
    vecs[8]  = '{4'b1000, 2'd3, 2'd3, 1'b1, 1'b0};
    vecs[9]  = '{4'b1001, 2'd3, 2'd0, 1'b1, 1'b1};
    vecs[10] = '{4'b1010, 2'd3, 2'd1, 1'b1, 1'b1};
    vecs[11] = '{4'b1011, 2'd3, 2'd0, 1'b1, 1'b1};
    vecs[12] = '{4'b1100, 2'd3, 2'd2, 1'b1, 1'b1};
    vecs[13] = '{4'b1101, 2'd3, 2'd0, 1'b1, 1'b1};
    vecs[14] = '{4'b1110, 2'd3, 2'd1, 1'b1, 1'b1};
    vecs[15] = '{4'b1111, 2'd3, 2'd0, 1'b1, 1'b1};
    vecs[16] = '{4'b0000, 2'd0, 2'd0, 1'b0, 1'b0};

    // Reset held with a live request: registered outputs stay cleared.
    rst_n = 1'b0;
    w     = 4'b1000;
    #1;
    chk_msb("reset_async", 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_msb("reset_hold_msb", 2'd0, 1'b0, 1'b0);
      chk_lsb("reset_hold_lsb", 2'd0, 1'b0, 1'b0);
    end

    // First capture on the first edge after release.
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_msb("reset_release_msb", 2'd3, 1'b1, 1'b0);
    chk_lsb("reset_release_lsb", 2'd3, 1'b1, 1'b0);

    // One-hot sweep on successive cycles.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] oh;
      logic [1:0] idx;
      oh  = 4'b0001 << i;
      idx = 2'(i);
      w   = oh;
      @(posedge clk); #1;
      chk_msb("onehot_msb", idx, 1'b1, 1'b0);
      chk_lsb("onehot_lsb", idx, 1'b1, 1'b0);
    end

    // Full sweep 0..15 and wrap back to 0.
    prev = '{4'b1000, 2'd3, 2'd3, 1'b1, 1'b0};
    for (int i = 0; i < 17; i++) begin
      w = vecs[i].w;
      #1;
      chk_comb("sweep_comb", vecs[i].y_msb, vecs[i].valid, vecs[i].multi);
      chk_msb("sweep_hold_msb", prev.y_msb, prev.valid, prev.multi);
      @(posedge clk); #1;
      chk_msb("sweep_msb", vecs[i].y_msb, vecs[i].valid, vecs[i].multi);
      chk_lsb("sweep_lsb", vecs[i].y_lsb, vecs[i].valid, vecs[i].multi);
      prev = vecs[i];
    end

    // Reset pulse between edges with a steady request.
    w = 4'b0100;
    @(posedge clk); #1;
    chk_msb("midstream_pre", 2'd2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_msb("midstream_async_msb", 2'd0, 1'b0, 1'b0);
    chk_lsb("midstream_async_lsb", 2'd0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    chk_msb("midstream_hold", 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_msb("midstream_release", 2'd2, 1'b1, 1'b0);

    // Combinational instance responds without a clock edge.
    w = 4'b0010;
    #1;
    chk_comb("comb_a", 2'd1, 1'b1, 1'b0);
    w = 4'b1001;
    #1;
    chk_comb("comb_b", 2'd3, 1'b1, 1'b1);
    chk_msb("comb_b_regs_hold", 2'd2, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
